// File: rtl/cdb_arbiter_pkg.sv
// Shared core types: functional-unit tags and the index/tag helpers used by the CDB arbiter.
package types;

   localparam int NUM_FUNCTIONAL_UNITS = 4;
   localparam int FU_TAG_W             = 2;

   typedef enum logic [FU_TAG_W-1:0] {
      FU_ALU = 2'd0,
      FU_MUL = 2'd1,
      FU_LSU = 2'd2,
      FU_BRU = 2'd3
   } e_functional_unit;

   // Station index i is the producer tag e_functional_unit'(i).
   function automatic e_functional_unit fu_from_index(input int idx);
      logic [FU_TAG_W-1:0] tag;
      tag = idx[FU_TAG_W-1:0];
      return e_functional_unit'(tag);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after start_i, searching upward with wrap.
module rr_picker
   import types::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   int pos;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = 0;
      for (int k = 0; k < N; k++) begin
         // Two subtractions cover an out-of-range start on non-power-of-two N.
         pos = int'(start_i) + k;
         if (pos >= N) pos = pos - N;
         if (pos >= N) pos = pos - N;
         if (!found_o && req_i[pos[IDX_W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one registered broadcast + retire pulse per cycle from the ready stations.
// Define CDB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest ready index wins.
module cdb_arbiter
   import types::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RS     = NUM_FUNCTIONAL_UNITS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_RS-1:0]                  ready_i,
   input  logic [NUM_RS-1:0][DATA_WIDTH-1:0]  result_i,
   output logic [NUM_RS-1:0]                  retire_o,
   output logic                               bcast_en_o,
   output logic [DATA_WIDTH-1:0]              bcast_data_o,
   output e_functional_unit                   bcast_rs_o
);

   localparam int IDX_W = idx_width(NUM_RS);

   logic [NUM_RS-1:0]     retire_q, retire_d;
   logic                  bcast_en_q, bcast_en_d;
   logic [DATA_WIDTH-1:0] bcast_data_q, bcast_data_d;
   e_functional_unit      bcast_rs_q, bcast_rs_d;

   logic [NUM_RS-1:0]     cand;
   logic [IDX_W-1:0]      start;
   logic                  found;
   logic [IDX_W-1:0]      win;

   // The station being retired still shows ready until this edge; masking it avoids a double grant.
   assign cand = ready_i & ~retire_q;

   rr_picker #(
      .N     (NUM_RS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (cand),
      .start_i (start),
      .found_o (found),
      .idx_o   (win)
   );

`ifdef CDB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   assign start = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (int'(win) == NUM_RS - 1) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   assign start = '0;
`endif

   always_comb begin
      retire_d     = '0;
      bcast_en_d   = 1'b0;
      bcast_data_d = '0;
      bcast_rs_d   = fu_from_index(0);
      if (found) begin
         retire_d[win] = 1'b1;
         bcast_en_d    = 1'b1;
         bcast_data_d  = result_i[win];
         bcast_rs_d    = fu_from_index(int'(win));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_q     <= '0;
         bcast_en_q   <= 1'b0;
         bcast_data_q <= '0;
         bcast_rs_q   <= fu_from_index(0);
      end else begin
         retire_q     <= retire_d;
         bcast_en_q   <= bcast_en_d;
         bcast_data_q <= bcast_data_d;
         bcast_rs_q   <= bcast_rs_d;
      end
   end

   assign retire_o     = retire_q;
   assign bcast_en_o   = bcast_en_q;
   assign bcast_data_o = bcast_data_q;
   assign bcast_rs_o   = bcast_rs_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, reset-mid-grant sequence, and a random scoreboard run.
module tb_cdb_arbiter;
   import types::*;

   logic                  clk;
   logic                  rst;
   logic [3:0]            ready_i;
   logic [3:0][31:0]      result_i;
   logic [3:0]            retire_o;
   logic                  bcast_en_o;
   logic [31:0]           bcast_data_o;
   e_functional_unit      bcast_rs_o;

   cdb_arbiter #(
      .DATA_WIDTH (32),
      .NUM_RS     (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ready_i      (ready_i),
      .result_i     (result_i),
      .retire_o     (retire_o),
      .bcast_en_o   (bcast_en_o),
      .bcast_data_o (bcast_data_o),
      .bcast_rs_o   (bcast_rs_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected word: {retire[3:0], en, rs[1:0], data[31:0]}
   logic [38:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  rdy;
      logic [3:0]  retire;
      logic        en;
      logic [1:0]  rs;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[$];

   logic [31:0] res_c [4];

   // reference model state for the random run
   logic [3:0] m_retire;
   logic [1:0] m_ptr;

   function automatic logic [38:0] pk(input logic [3:0] r, input logic e,
                                      input logic [1:0] s, input logic [31:0] d);
      return {r, e, s, d};
   endfunction

   function automatic vec_t mk(input logic r, input logic [3:0] rdy, input logic [3:0] ret,
                               input logic e, input logic [1:0] s, input logic [31:0] d);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.retire = ret; v.en = e; v.rs = s; v.data = d;
      return v;
   endfunction

   task automatic check_out(input string name);
      logic [38:0] e;
      logic [38:0] a;
      logic [1:0]  rs_a;
      rs_a = bcast_rs_o;
      a = {retire_o, bcast_en_o, rs_a, bcast_data_o};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, actual retire=%b en=%b rs=%0d data=%h",
                  name, retire_o, bcast_en_o, rs_a, bcast_data_o);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: actual retire=%b en=%b rs=%0d data=%h expected retire=%b en=%b rs=%0d data=%h",
                     name, $time, a[38:35], a[34], a[33:32], a[31:0],
                     e[38:35], e[34], e[33:32], e[31:0]);
         end
      end
   endtask

   // driver: apply inputs for one cycle, push the expectation, compare after the edge
   task automatic drive_cycle(input logic r, input logic [3:0] rdy,
                              input logic [38:0] exp, input string name);
      rst     = r;
      ready_i = rdy;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      check_out(name);
   endtask

   task automatic model_cycle(input logic r, input logic [3:0] rdy);
      logic [3:0]  cand;
      logic [1:0]  start;
      logic [38:0] exp;
      logic [1:0]  w;
      logic        hit;
      cand = rdy & ~m_retire;
`ifdef CDB_ROUND_ROBIN_EN
      start = m_ptr;
`else
      start = 2'd0;
`endif
      hit = 1'b0;
      w   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] i;
         i = start + k[1:0];
         if (!hit && cand[i]) begin
            hit = 1'b1;
            w   = i;
         end
      end
      if (r) begin
         exp      = '0;
         m_retire = 4'b0;
         m_ptr    = 2'd0;
      end else if (hit) begin
         exp      = pk(4'b0001 << w, 1'b1, w, result_i[w]);
         m_retire = 4'b0001 << w;
         m_ptr    = w + 2'd1;
      end else begin
         exp      = '0;
         m_retire = 4'b0;
      end
      drive_cycle(r, rdy, exp, "random");
   endtask

   initial begin
      rst      = 1'b1;
      ready_i  = 4'b0;
      res_c[0] = 32'hA0A0_0000;
      res_c[1] = 32'hB1B1_0001;
      res_c[2] = 32'hDEAD_BEEF;
      res_c[3] = 32'hC3C3_0003;
      for (int k = 0; k < 4; k++) result_i[k] = res_c[k];
      m_retire = 4'b0;
      m_ptr    = 2'd0;

      // reset state, then idle
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 32'h0));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0));
      // single station 2 ready, dropped after its retire
      vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 2, 32'hDEAD_BEEF));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 32'h0));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0));
      // all four ready, each drops after its retire
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 32'h0));
      vecs.push_back(mk(0, 4'b1111, 4'b0001, 1, 0, res_c[0]));
      vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 1, res_c[1]));
      vecs.push_back(mk(0, 4'b1110, 4'b0100, 1, 2, res_c[2]));
      vecs.push_back(mk(0, 4'b1100, 4'b1000, 1, 3, res_c[3]));
      vecs.push_back(mk(0, 4'b1000, 4'b0000, 0, 0, 32'h0));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0));
      // 1001 held: masking forces 0,3,0,3
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 32'h0));
      for (int k = 0; k < 2; k++) begin
         vecs.push_back(mk(0, 4'b1001, 4'b0001, 1, 0, res_c[0]));
         vecs.push_back(mk(0, 4'b1001, 4'b1000, 1, 3, res_c[3]));
      end
      // 0011 held: 0,1,0,1
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 32'h0));
      for (int k = 0; k < 2; k++) begin
         vecs.push_back(mk(0, 4'b0011, 4'b0001, 1, 0, res_c[0]));
         vecs.push_back(mk(0, 4'b0011, 4'b0010, 1, 1, res_c[1]));
      end

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         drive_cycle(vecs[i].rst, vecs[i].rdy,
                     pk(vecs[i].retire, vecs[i].en, vecs[i].rs, vecs[i].data), "vector");
      end

      // reset while a grant to station 1 is registered; pointer must restart at 0
      drive_cycle(1, 4'b0000, pk(4'b0000, 0, 0, 32'h0), "rst_mid_pre");
      drive_cycle(0, 4'b0010, pk(4'b0010, 1, 1, res_c[1]), "rst_mid_grant");
      drive_cycle(1, 4'b1010, pk(4'b0000, 0, 0, 32'h0), "rst_mid_drop");
      drive_cycle(0, 4'b1010, pk(4'b0010, 1, 1, res_c[1]), "rst_mid_first");
      drive_cycle(0, 4'b1010, pk(4'b1000, 1, 3, res_c[3]), "rst_mid_next");

      // random run against the reference model
      model_cycle(1, 4'b0000);
      for (int n = 0; n < 300; n++) begin
         logic r;
         for (int k = 0; k < 4; k++) result_i[k] = $urandom;
         r = ($urandom_range(0, 49) == 0);
         model_cycle(r, 4'($urandom_range(0, 15)));
      end

      rst     = 1'b0;
      ready_i = 4'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: actual %0d queued expectations, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the functional units' reservation stations and the rest of the out-of-order core. Each cycle it picks one reservation station reporting a finished result, broadcasts that result on the CDB for operand capture by all stations, and pulses that station's retire input so it frees itself. Sits directly downstream of every reservation station and drives their `bcast_*` and `retire_i` inputs.

## Interface
- `DATA_WIDTH`, 32: result/broadcast data width; matches the reservation stations.
- `NUM_RS`, 4: number of reservation stations arbitrated; station index i corresponds to `e_functional_unit'(i)`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ready_i` in NUM_RS: per-station `retirement_ready_o`.
- `result_i` in NUM_RS x DATA_WIDTH: per-station unit result; valid when the matching `ready_i` is high.
- `retire_o` out NUM_RS: one-hot or zero; drives each station's `retire_i`.
- `bcast_en_o` out 1: CDB valid.
- `bcast_data_o` out DATA_WIDTH: broadcast result.
- `bcast_rs_o` out e_functional_unit: tag of the producing station.

## Operation
- Candidate set each cycle: `ready_i & ~retire_o`. The station currently being retired is masked, because its `ready_i` is still high until the edge where its `retire_i` takes effect. This prevents a double grant.
- If the candidate set is non-empty, exactly one winner w is chosen. At the next edge:
  - `retire_o` <= one-hot(w)
  - `bcast_en_o` <= 1
  - `bcast_data_o` <= `result_i[w]`
  - `bcast_rs_o` <= `e_functional_unit'(w)`
- If the candidate set is empty, all of `retire_o`, `bcast_en_o`, `bcast_data_o` and `bcast_rs_o` are 0 at the next edge.
- Broadcast and retire for a winner are always in the same cycle. The station frees itself on that edge. Dependent stations capture `bcast_data_o` in the same cycle.
- Selection policy: see Configuration. The priority pointer `ptr` (clog2(NUM_RS) bits) updates only on a grant, to (w+1) mod NUM_RS, wrapping NUM_RS-1 -> 0.
- The data path is fully registered; there is no combinational path from `ready_i`/`result_i` to any output.

## Timing
- Latency: `ready_i[k]` rises in cycle N. If k wins, `bcast_en_o`/`retire_o[k]` are high in cycle N+1. `ready_i[k]` is low from N+2.
- Throughput: one broadcast per cycle when at least 2 stations are ready. A single ready station is granted at most every other cycle because of the masking.
- Reset values: `retire_o`=0, `bcast_en_o`=0, `bcast_data_o`=0, `bcast_rs_o`=0, `ptr`=0.
- Reset mid-grant: a registered grant is dropped. Outputs are 0 in the cycle after `rst` is sampled high; no retire pulse is emitted.
- All NUM_RS ready simultaneously: grants are issued in policy order, one per cycle. A station never sees two consecutive retire pulses.
- NUM_RS=1: `ptr` is 0 constant; the block alternates grant and idle while ready.

## Configuration
- `CDB_ROUND_ROBIN_EN` defined: round-robin. The winner is the first candidate at or after `ptr`, searching upward with wrap. No station waits more than NUM_RS-1 grants.
- Not defined: fixed priority. The lowest-index candidate wins, and `ptr` is not instantiated. Index 0 can starve others; this is acceptable only for debugging.

## Structure
- Package `types`:
  - Already holds `e_functional_unit`.
  - Add constant `NUM_FUNCTIONAL_UNITS` used as the default source for NUM_RS.
  - Add function `fu_from_index(int)` for the index-to-tag mapping.
- Sub-module `rr_picker`: purely combinational. Inputs are request vector and start pointer; outputs are a found flag and winner index. It is reused by the issue logic. In fixed-priority builds it is instantiated with start tied to 0.

## Test plan
- Reset, then `ready_i`=0000 for 5 cycles -> `bcast_en_o`=0 and `retire_o`=0000 throughout.
- `ready_i[2]`=1 with `result_i[2]`=32'hDEADBEEF, dropped after its retire -> next cycle `bcast_en_o`=1, `bcast_rs_o`=2, `bcast_data_o`=DEADBEEF, `retire_o`=0100. No second grant to station 2.
- `ready_i`=1111 held, each deasserting after its retire (round-robin) -> grant order 0,1,2,3 on 4 consecutive cycles, then `bcast_en_o`=0.
- `ready_i`=1001 held continuously (round-robin) -> grants alternate 0,3,0,3. No station is granted on consecutive cycles.
- Same stimulus without `CDB_ROUND_ROBIN_EN` -> grants 0,3,0,3 (masking forces the alternation). With `ready_i`=0011 held: 0,1,0,1, and index 0 always wins when it is unmasked.
- Assert `rst` in the cycle a grant to station 1 is pending -> next cycle `retire_o`=0000 and `bcast_en_o`=0. After release, `ptr`=0 and the first grant goes to the lowest ready index.
